// File: rtl/ram_rw_sequencer_pkg.sv
// Shared definitions for the audio RAM request initiator.
// Provides the sequencer state encoding, request type and bank select
// constants, the default sample width and a saturating counter helper.
package audio_ram_pkg;

  localparam int unsigned DW_DEFAULT = 16;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic TGT_RX = 1'b0;
  localparam logic TGT_TX = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR,
    S_WR_END,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ram_rw_sequencer_edge_rise.sv
// Rising-edge detector for a level command input.
// Ports:
//   clk      sample clock
//   rst_n    asynchronous active-low reset
//   i_level  level input
//   o_pulse  high for the cycle in which i_level is first seen high
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/ram_rw_sequencer.sv
// Initiator side of the audio RAM request interface.
// Turns record/play commands into request traffic toward the RAM
// read/write controller, streams ADC samples as a write burst and
// forwards read-back samples to the DAC. One sample per clk.
// Ports:
//   clk, rst_n                     sample clock, async active-low reset
//   rec_start/rec_stop             record command levels (edge-detected)
//   play_start/play_stop           playback command levels (edge-detected)
//   target_sel                     bank select, sampled at command accept
//   adc_l/adc_r                    ADC samples
//   req_valid/req_type/req_target  request to the RAM controller
//   stop                           read abort strobe
//   data_in_l/data_in_r            write data (registered ADC)
//   req_ready/busy                 controller handshake/status
//   data_valid/data_out_l/r        read data from the controller
//   dac_valid/dac_l/dac_r          playback samples
//   rec_len/play_cnt               word counters
//   active/done/err                status
module ram_rw_sequencer
  import audio_ram_pkg::*;
#(
  parameter int unsigned DW          = DW_DEFAULT,
  parameter logic [15:0] MAX_WORDS   = 16'hFFFE,
  parameter int unsigned REQ_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rec_start,
  input  logic          rec_stop,
  input  logic          play_start,
  input  logic          play_stop,
  input  logic          target_sel,
  input  logic [DW-1:0] adc_l,
  input  logic [DW-1:0] adc_r,
  output logic          req_valid,
  output logic          req_type,
  output logic          req_target,
  output logic          stop,
  output logic [DW-1:0] data_in_l,
  output logic [DW-1:0] data_in_r,
  input  logic          req_ready,
  input  logic          busy,
  input  logic          data_valid,
  input  logic [DW-1:0] data_out_l,
  input  logic [DW-1:0] data_out_r,
  output logic          dac_valid,
  output logic [DW-1:0] dac_l,
  output logic [DW-1:0] dac_r,
  output logic [15:0]   rec_len,
  output logic [15:0]   play_cnt,
  output logic          active,
  output logic          done,
  output logic          err
);

  localparam logic [7:0] TMO_LAST = 8'(REQ_TIMEOUT - 1);

  logic          w_rec_start_p;
  logic          w_rec_stop_p;
  logic          w_play_start_p;
  logic          w_play_stop_p;

  state_t        r_state;
  state_t        w_next;
  logic          w_timeout;
  logic [15:0]   w_rec_len_inc;

  logic [7:0]    r_tmo;
  logic          r_stop_pend;
  logic          r_target;
  logic          r_type;
  logic [DW-1:0] r_data_l;
  logic [DW-1:0] r_data_r;
  logic [DW-1:0] r_dac_l;
  logic [DW-1:0] r_dac_r;
  logic          r_dac_valid;
  logic [15:0]   r_rec_len;
  logic [15:0]   r_play_cnt;
  logic          r_stop;
  logic          r_done;
  logic          r_err;

  edge_rise u_edge_rec_start (
    .clk(clk), .rst_n(rst_n), .i_level(rec_start), .o_pulse(w_rec_start_p)
  );
  edge_rise u_edge_rec_stop (
    .clk(clk), .rst_n(rst_n), .i_level(rec_stop), .o_pulse(w_rec_stop_p)
  );
  edge_rise u_edge_play_start (
    .clk(clk), .rst_n(rst_n), .i_level(play_start), .o_pulse(w_play_start_p)
  );
  edge_rise u_edge_play_stop (
    .clk(clk), .rst_n(rst_n), .i_level(play_stop), .o_pulse(w_play_stop_p)
  );

  assign w_rec_len_inc = r_rec_len + 16'd1;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rec_start_p)       w_next = S_WR_REQ;
        else if (w_play_start_p) w_next = S_RD_REQ;
      end
      S_WR_REQ: begin
        // A stop seen before or during acceptance yields a zero-word burst.
        if (req_ready) begin
          w_next = (r_stop_pend || w_rec_stop_p) ? S_WR_END : S_WR;
        end else if (r_tmo == TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WR: begin
        // The current cycle's word is still written; req_valid drops after it.
        if (w_rec_stop_p || (w_rec_len_inc == MAX_WORDS)) w_next = S_WR_END;
      end
      S_WR_END: begin
        if (!busy) w_next = S_IDLE;
      end
      S_RD_REQ: begin
        if (req_ready) begin
          w_next = S_RD_WAIT;
        end else if (r_tmo == TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (busy) begin
          w_next = S_RD;
        end else if (r_tmo == TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RD: begin
        if (!busy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_stop_pend <= 1'b0;
      r_target    <= TGT_RX;
      r_type      <= REQ_READ;
      r_data_l    <= '0;
      r_data_r    <= '0;
      r_dac_l     <= '0;
      r_dac_r     <= '0;
      r_dac_valid <= 1'b0;
      r_rec_len   <= '0;
      r_play_cnt  <= '0;
      r_stop      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_done      <= 1'b0;
      r_dac_valid <= 1'b0;
      r_stop      <= 1'b0;

      if (w_next != r_state) begin
        r_tmo <= '0;
      end else if (r_state == S_WR_REQ || r_state == S_RD_REQ ||
                   r_state == S_RD_WAIT) begin
        r_tmo <= r_tmo + 8'd1;
      end

      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_target <= target_sel;
        r_err    <= 1'b0;
        if (w_next == S_WR_REQ) begin
          r_type    <= REQ_WRITE;
          r_rec_len <= '0;
        end else begin
          r_type     <= REQ_READ;
          r_play_cnt <= '0;
        end
      end

      if (w_timeout) r_err <= 1'b1;

      if (r_state == S_WR_REQ) begin
        if (w_rec_stop_p) r_stop_pend <= 1'b1;
      end else begin
        r_stop_pend <= 1'b0;
      end

      if (r_state == S_WR_REQ || r_state == S_WR) begin
        r_data_l <= adc_l;
        r_data_r <= adc_r;
      end

      if (r_state == S_WR) r_rec_len <= w_rec_len_inc;

      if ((r_state == S_WR_END || r_state == S_RD) && !busy) r_done <= 1'b1;

      if (r_state == S_RD) begin
        if (data_valid) begin
          r_dac_l     <= data_out_l;
          r_dac_r     <= data_out_r;
          r_dac_valid <= 1'b1;
          r_play_cnt  <= sat_inc16(r_play_cnt);
        end
        if (w_play_stop_p && busy) r_stop <= 1'b1;
      end
    end
  end

  assign req_valid  = (r_state == S_WR_REQ) || (r_state == S_WR) ||
                      (r_state == S_RD_REQ);
  assign req_type   = r_type;
  assign req_target = r_target;
  assign stop       = r_stop;
  assign data_in_l  = r_data_l;
  assign data_in_r  = r_data_r;
  assign dac_valid  = r_dac_valid;
  assign dac_l      = r_dac_l;
  assign dac_r      = r_dac_r;
  assign rec_len    = r_rec_len;
  assign play_cnt   = r_play_cnt;
  assign active     = (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_ram_rw_sequencer.sv
module tb_ram_rw_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rec_start, rec_stop, play_start, play_stop, target_sel;
  logic [15:0] adc_l, adc_r;
  logic        req_valid, req_type, req_target, stop;
  logic [15:0] data_in_l, data_in_r;
  logic        req_ready;
  logic        busy = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_out_l = '0, data_out_r = '0;
  logic        dac_valid;
  logic [15:0] dac_l, dac_r, rec_len, play_cnt;
  logic        active, done, err;

  logic        c_rec_start;
  logic        c_req_valid, c_req_type, c_req_target, c_stop;
  logic [15:0] c_data_in_l, c_data_in_r;
  logic        c_dac_valid;
  logic [15:0] c_dac_l, c_dac_r, c_rec_len, c_play_cnt;
  logic        c_active, c_done, c_err;

  ram_rw_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .rec_start(rec_start), .rec_stop(rec_stop),
    .play_start(play_start), .play_stop(play_stop),
    .target_sel(target_sel), .adc_l(adc_l), .adc_r(adc_r),
    .req_valid(req_valid), .req_type(req_type), .req_target(req_target),
    .stop(stop), .data_in_l(data_in_l), .data_in_r(data_in_r),
    .req_ready(req_ready), .busy(busy), .data_valid(data_valid),
    .data_out_l(data_out_l), .data_out_r(data_out_r),
    .dac_valid(dac_valid), .dac_l(dac_l), .dac_r(dac_r),
    .rec_len(rec_len), .play_cnt(play_cnt),
    .active(active), .done(done), .err(err)
  );

  // Second instance with a tiny burst cap; its controller is always idle-ready.
  ram_rw_sequencer #(.MAX_WORDS(16'd4)) dut_cap (
    .clk(clk), .rst_n(rst_n),
    .rec_start(c_rec_start), .rec_stop(1'b0),
    .play_start(1'b0), .play_stop(1'b0),
    .target_sel(1'b1), .adc_l(adc_l), .adc_r(adc_r),
    .req_valid(c_req_valid), .req_type(c_req_type), .req_target(c_req_target),
    .stop(c_stop), .data_in_l(c_data_in_l), .data_in_r(c_data_in_r),
    .req_ready(1'b1), .busy(1'b0), .data_valid(1'b0),
    .data_out_l(16'h0000), .data_out_r(16'h0000),
    .dac_valid(c_dac_valid), .dac_l(c_dac_l), .dac_r(c_dac_r),
    .rec_len(c_rec_len), .play_cnt(c_play_cnt),
    .active(c_active), .done(c_done), .err(c_err)
  );

  // RAM controller model: accepts one request when idle, stores write bursts
  // per bank, replays a bank one word per cycle with busy falling alongside
  // the last word, and aborts on stop.
  logic        ready_en;
  int          cst = 0;
  int          cbank = 0, waddr = 0, raddr = 0;
  int          mlen [2] = '{0, 0};
  int          n_emit = 0;
  logic [15:0] mem_l [2][64];
  logic [15:0] mem_r [2][64];

  assign req_ready = ready_en && (cst == 0);

  always @(posedge clk) begin
    case (cst)
      0: begin
        data_valid <= 1'b0;
        if (req_valid && req_ready) begin
          cbank <= req_target ? 1 : 0;
          busy  <= 1'b1;
          waddr <= 0;
          raddr <= 0;
          cst   <= req_type ? 1 : 2;
        end
      end
      1: begin
        if (req_valid) begin
          if (waddr < 64) begin
            mem_l[cbank][waddr] <= data_in_l;
            mem_r[cbank][waddr] <= data_in_r;
          end
          waddr <= waddr + 1;
        end else begin
          mlen[cbank] <= waddr;
          busy        <= 1'b0;
          cst         <= 0;
        end
      end
      2: begin
        if (stop || raddr >= mlen[cbank]) begin
          busy       <= 1'b0;
          data_valid <= 1'b0;
          cst        <= 0;
        end else begin
          data_valid <= 1'b1;
          data_out_l <= mem_l[cbank][raddr];
          data_out_r <= mem_r[cbank][raddr];
          n_emit     <= n_emit + 1;
          raddr      <= raddr + 1;
          if (raddr + 1 >= mlen[cbank]) begin
            busy <= 1'b0;
            cst  <= 0;
          end
        end
      end
      default: cst <= 0;
    endcase
  end

  // Output monitors, cumulative; the main sequence works with differences.
  int          m_rv = 0, m_done = 0, m_stop_cyc = 0, m_stop_pulse = 0;
  int          m_dac_n = 0, m_dac_idle = 0, m_stop_idle = 0, m_tgt_chg = 0;
  int          m_cap_rv = 0, m_cap_done = 0;
  logic        prev_stop = 1'b0, prev_active = 1'b0, prev_tgt = 1'b0;
  logic [15:0] m_dac_l [$];
  logic [15:0] m_dac_r [$];

  always @(negedge clk) begin
    if (req_valid) m_rv++;
    if (done) m_done++;
    if (stop) m_stop_cyc++;
    if (stop && !prev_stop) m_stop_pulse++;
    if (stop && !active) m_stop_idle++;
    if (dac_valid) begin
      m_dac_n++;
      m_dac_l.push_back(dac_l);
      m_dac_r.push_back(dac_r);
    end
    if (dac_valid && !active && !done) m_dac_idle++;
    if (active && prev_active && (req_target !== prev_tgt)) m_tgt_chg++;
    if (c_req_valid) m_cap_rv++;
    if (c_done) m_cap_done++;
    prev_stop   = stop;
    prev_active = active;
    prev_tgt    = req_target;
  end

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] ref_l [2][64];
  logic [15:0] ref_r [2][64];
  int          ref_len [2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (active && k < 200) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, active}, 32'd0);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"},
        {24'd0, req_valid, req_type, req_target, stop, dac_valid, active, done, err}, 32'd0);
    chk({tag, "_data"},
        {16'd0, data_in_l | data_in_r | dac_l | dac_r | rec_len | play_cnt}, 32'd0);
  endtask

  task automatic record(input logic bank, input int n, input bit both, input bit rnd);
    int b_rv = m_rv;
    int b_done = m_done;
    int bi = bank ? 1 : 0;
    int mism = 0;
    for (int i = 0; i < n; i++) begin
      ref_l[bi][i] = rnd ? 16'($urandom) : 16'(i + 1);
      ref_r[bi][i] = rnd ? 16'($urandom) : 16'(16'h100 + i + 1);
    end
    ref_len[bi] = n;
    target_sel = bank;
    rec_start  = 1'b1;
    play_start = both;
    tick();
    rec_start  = 1'b0;
    play_start = 1'b0;
    chk("wr_req_valid", {31'd0, req_valid}, 32'd1);
    chk("wr_req_type", {31'd0, req_type}, 32'd1);
    chk("wr_req_target", {31'd0, req_target}, {31'd0, bank});
    chk("wr_err_clear", {31'd0, err}, 32'd0);
    for (int i = 0; i < n; i++) begin
      adc_l = ref_l[bi][i];
      adc_r = ref_r[bi][i];
      tick();
    end
    rec_stop = 1'b1;
    adc_l = 16'($urandom);
    adc_r = 16'($urandom);
    tick();
    rec_stop = 1'b0;
    wait_idle("wr_idle");
    chk("wr_rec_len", {16'd0, rec_len}, n);
    chk("wr_rv_cycles", m_rv - b_rv, n + 1);
    chk("wr_done_cnt", m_done - b_done, 1);
    chk("wr_mem_len", mlen[bi], n);
    for (int i = 0; i < n; i++)
      if (mem_l[bi][i] !== ref_l[bi][i] || mem_r[bi][i] !== ref_r[bi][i]) mism++;
    chk("wr_data", mism, 0);
  endtask

  task automatic play(input logic bank, input int stop_after);
    int b_dac = m_dac_n;
    int b_emit = n_emit;
    int b_done = m_done;
    int b_sp = m_stop_pulse;
    int b_sc = m_stop_cyc;
    int bi = bank ? 1 : 0;
    int cnt, emitted, k;
    int mism = 0;
    target_sel = bank;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("rd_req_valid", {31'd0, req_valid}, 32'd1);
    chk("rd_req_type", {31'd0, req_type}, 32'd0);
    chk("rd_req_target", {31'd0, req_target}, {31'd0, bank});
    if (stop_after >= 0) begin
      k = 0;
      while ((m_dac_n - b_dac) < stop_after && k < 100) begin
        tick();
        k++;
      end
      play_stop = 1'b1;
      tick();
      play_stop = 1'b0;
    end
    wait_idle("rd_idle");
    cnt     = m_dac_n - b_dac;
    emitted = n_emit - b_emit;
    chk("rd_dac_vs_ctrl", cnt, emitted);
    chk("rd_play_cnt", {16'd0, play_cnt}, emitted);
    chk("rd_done_cnt", m_done - b_done, 1);
    if (stop_after < 0) begin
      chk("rd_dac_count", cnt, ref_len[bi]);
      chk("rd_no_stop", m_stop_pulse - b_sp, 0);
    end else begin
      chk("rd_stop_pulses", m_stop_pulse - b_sp, 1);
      chk("rd_stop_width", m_stop_cyc - b_sc, 1);
      chk("rd_stop_cut", {31'd0, cnt < ref_len[bi]}, 32'd1);
    end
    for (int i = 0; i < cnt && i < 64; i++)
      if (m_dac_l[b_dac + i] !== ref_l[bi][i] || m_dac_r[b_dac + i] !== ref_r[bi][i]) mism++;
    chk("rd_data", mism, 0);
  endtask

  initial begin
    int b_rv, b_done;
    rst_n = 1'b0;
    rec_start = 1'b0; rec_stop = 1'b0; play_start = 1'b0; play_stop = 1'b0;
    target_sel = 1'b0; adc_l = '0; adc_r = '0;
    c_rec_start = 1'b0;
    ready_en = 1'b1;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();

    record(1'b0, 5, 1'b0, 1'b0);
    play(1'b0, -1);

    record(1'b1, 12, 1'b0, 1'b1);
    play(1'b1, 2);

    b_rv   = m_cap_rv;
    b_done = m_cap_done;
    c_rec_start = 1'b1;
    tick();
    c_rec_start = 1'b0;
    repeat (10) tick();
    chk("cap_rec_len", {16'd0, c_rec_len}, 32'd4);
    chk("cap_rv_cycles", m_cap_rv - b_rv, 5);
    chk("cap_done_cnt", m_cap_done - b_done, 1);
    chk("cap_idle", {30'd0, c_active, c_req_valid}, 32'd0);

    ready_en = 1'b0;
    b_rv   = m_rv;
    b_done = m_done;
    rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    wait_idle("tmo_idle");
    chk("tmo_rv_cycles", m_rv - b_rv, 8);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_no_done", m_done - b_done, 0);
    chk("tmo_req_valid", {31'd0, req_valid}, 32'd0);
    ready_en = 1'b1;

    record(1'b1, int'($urandom_range(1, 10)), 1'b1, 1'b1);
    play(1'b1, -1);

    record(1'b0, 0, 1'b0, 1'b0);
    play(1'b0, -1);

    b_done = m_done;
    target_sel = 1'b0;
    rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    adc_l = 16'hA5A5;
    adc_r = 16'h5A5A;
    tick();
    tick();
    chk("mid_rec_valid", {31'd0, req_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #10;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_no_done", m_done - b_done, 0);
    chk("rst_ctrl_idle", cst, 0);

    chk("tgt_stable", m_tgt_chg, 0);
    chk("stop_only_active", m_stop_idle, 0);
    chk("dac_not_idle", m_dac_idle, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
